// File: rtl/rx_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_timer_pkg
// Description : Shared defaults and helpers for the UART RX bit timer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_timer_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_SAMPLE_POINT = 10;
    localparam int DEFAULT_NUM_BITS     = 9;

    // Bits needed to hold the values 0..max inclusive
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_flex_counter
// Description : Up-counter with synchronous clear and programmable rollover.
//               Counts 1..rollover_val, wrapping back to 1; clear wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear first, then advance with wrap to 1 at rollover
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = WIDTH'(1);
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer
// Description : UART RX bit-period timer. Emits a one-cycle shift strobe at
//               the sample point of each bit and a one-cycle packet_done
//               after the final bit, then freezes until enable drops.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = DEFAULT_SAMPLE_POINT,
    parameter int NUM_BITS     = DEFAULT_NUM_BITS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    output logic       shift_strobe,
    output logic       packet_done,
    output logic [3:0] bit_idx
);

    localparam int CW = cnt_width(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_CLKS_PER_BIT = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_SAMPLE_POINT = CW'(SAMPLE_POINT);
    localparam logic [3:0]    c_NUM_BITS     = 4'(NUM_BITS);
    localparam logic [3:0]    c_LAST_BIT     = 4'(NUM_BITS - 1);

    if ((SAMPLE_POINT < 1) || (SAMPLE_POINT > CLKS_PER_BIT)) begin : g_bad_sample_point
        $error("rx_bit_timer: SAMPLE_POINT must lie in 1..CLKS_PER_BIT");
    end
    if (NUM_BITS > 15) begin : g_bad_num_bits
        $error("rx_bit_timer: NUM_BITS must not exceed 15");
    end

    logic [CW-1:0] w_clk_cnt;
    logic [3:0]    w_bit_cnt;
    logic          w_clear;
    logic          w_period_en;
    logic          w_strobe;
    logic          w_last_bit;
    logic          done_flag_q;
    logic          done_flag_d;
    logic          done_seen_q;
    logic          done_seen_d;

    // Dropping enable restarts everything; completion freezes the period count
    assign w_clear     = !enable_timer;
    assign w_period_en = enable_timer && !done_flag_q;

    // Strobe decoded purely from registered state
    assign w_strobe   = (w_clk_cnt == c_SAMPLE_POINT) && (w_bit_cnt < c_NUM_BITS) && !done_flag_q;
    assign w_last_bit = (w_bit_cnt == c_LAST_BIT);

    sync_flex_counter #(
        .WIDTH (CW)
    ) u_period_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_clear),
        .count_enable (w_period_en),
        .rollover_val (c_CLKS_PER_BIT),
        .count        (w_clk_cnt)
    );

    // Only strobes advance the bit count, and strobes stop at NUM_BITS,
    // so the rollover value is never reached through an increment.
    sync_flex_counter #(
        .WIDTH (4)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_clear),
        .count_enable (w_strobe),
        .rollover_val (c_NUM_BITS),
        .count        (w_bit_cnt)
    );

    // Completion flags: done sets on the last strobe, seen follows one edge later
    always_comb begin
        done_flag_d = done_flag_q;
        done_seen_d = done_seen_q;
        if (!enable_timer) begin
            done_flag_d = 1'b0;
            done_seen_d = 1'b0;
        end else begin
            if (w_strobe && w_last_bit) begin
                done_flag_d = 1'b1;
            end
            done_seen_d = done_flag_q;
        end
    end

    // Completion flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            done_flag_q <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            done_flag_q <= done_flag_d;
            done_seen_q <= done_seen_d;
        end
    end

    assign shift_strobe = w_strobe;
    assign packet_done  = done_flag_q && !done_seen_q;
    assign bit_idx      = w_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_bit_timer
// Description : Directed self-checking bench for rx_bit_timer (default
//               parameters and a 16/8/9 configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_bit_timer;

    logic       clk;
    logic       n_rst_a, en_a;
    logic       n_rst_b, en_b;
    logic       strobe_a, done_a, strobe_b, done_b;
    logic [3:0] idx_a, idx_b;

    int errors = 0;
    int checks = 0;

    rx_bit_timer u_dut_a (
        .clk          (clk),
        .n_rst        (n_rst_a),
        .enable_timer (en_a),
        .shift_strobe (strobe_a),
        .packet_done  (done_a),
        .bit_idx      (idx_a)
    );

    rx_bit_timer #(
        .CLKS_PER_BIT (16),
        .SAMPLE_POINT (8),
        .NUM_BITS     (9)
    ) u_dut_b (
        .clk          (clk),
        .n_rst        (n_rst_b),
        .enable_timer (en_b),
        .shift_strobe (strobe_b),
        .packet_done  (done_b),
        .bit_idx      (idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    // All three outputs of the selected DUT must be zero
    task automatic chk_zero(input int sel, input string tag);
        chk({tag, "_strobe"}, 0, (sel == 0) ? {3'b0, strobe_a} : {3'b0, strobe_b}, 4'd0);
        chk({tag, "_done"},   0, (sel == 0) ? {3'b0, done_a}   : {3'b0, done_b},   4'd0);
        chk({tag, "_idx"},    0, (sel == 0) ? idx_a : idx_b,                       4'd0);
    endtask

    // Check cycles k0..k0+ncyc-1 against the bit-timing schedule, ticking after each
    task automatic run_cycles(input int sel, input int k0, input int ncyc,
                              input int cpb, input int sp, input int nb);
        for (int c = 0; c < ncyc; c++) begin
            int k;
            int n_before;
            logic [3:0] e_strobe, e_done, e_idx;
            k = k0 + c;
            e_strobe = ((k >= sp) && (((k - sp) % cpb) == 0) && (((k - sp) / cpb) < nb)) ? 4'd1 : 4'd0;
            e_done   = (k == sp + (nb - 1) * cpb + 1) ? 4'd1 : 4'd0;
            n_before = (k <= sp) ? 0 : ((k - sp - 1) / cpb + 1);
            if (n_before > nb) n_before = nb;
            e_idx = 4'(n_before);
            chk("strobe", k, (sel == 0) ? {3'b0, strobe_a} : {3'b0, strobe_b}, e_strobe);
            chk("done",   k, (sel == 0) ? {3'b0, done_a}   : {3'b0, done_b},   e_done);
            chk("bit_idx", k, (sel == 0) ? idx_a : idx_b, e_idx);
            tick();
        end
    endtask

    initial begin
        n_rst_a = 1'b0; en_a = 1'b1;
        n_rst_b = 1'b0; en_b = 1'b0;

        // 1: reset held 3 edges with enable high, then first strobe in cycle 10
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero(0, "rst_hold");
        end
        n_rst_a = 1'b1;
        tick();
        run_cycles(0, 1, 12, 10, 10, 9);
        en_a = 1'b0;
        tick();
        chk_zero(0, "en_low_after_rst");

        // 2 and 3: single packet, then enable held to cycle 200 with no more activity
        en_a = 1'b1;
        tick();
        run_cycles(0, 1, 200, 10, 10, 9);

        // 5: enable low for exactly one cycle, then a second packet
        en_a = 1'b0;
        tick();
        chk_zero(0, "gap1_a");
        en_a = 1'b1;
        tick();
        run_cycles(0, 1, 95, 10, 10, 9);
        en_a = 1'b0;
        tick();
        chk_zero(0, "gap1_b");
        en_a = 1'b1;
        tick();
        run_cycles(0, 1, 100, 10, 10, 9);

        // 4: drop enable at cycle 35, low for 2 cycles, then a full packet
        en_a = 1'b0;
        tick();
        en_a = 1'b1;
        tick();
        run_cycles(0, 1, 34, 10, 10, 9);
        chk("mid_idx_c35", 35, idx_a, 4'd3);
        en_a = 1'b0;
        tick();
        chk_zero(0, "drop_low1");
        tick();
        chk_zero(0, "drop_low2");
        en_a = 1'b1;
        tick();
        run_cycles(0, 1, 95, 10, 10, 9);

        // 6: 16/8/9 configuration, full packet then reset at cycle 50
        tick();
        chk_zero(1, "b_rst");
        n_rst_b = 1'b1;
        en_b    = 1'b1;
        tick();
        run_cycles(1, 1, 145, 16, 8, 9);
        en_b = 1'b0;
        tick();
        chk_zero(1, "b_gap");
        en_b = 1'b1;
        tick();
        run_cycles(1, 1, 49, 16, 8, 9);
        n_rst_b = 1'b0;
        tick();
        chk_zero(1, "b_rst50");
        n_rst_b = 1'b1;
        tick();
        run_cycles(1, 1, 10, 16, 8, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Bit-period timing stage for the UART receive path. Runs while the receiver control unit holds enable_timer high.
- Produces a one-cycle shift_strobe at the sample point of every bit period and a one-cycle packet_done after the final bit (data + stop) has been strobed.
- Its outputs feed the receive shift register (shift_strobe) and the receiver control FSM (packet_done).

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range 2..255
SAMPLE_POINT, 10, value of the period counter at which the bit is sampled; legal range 1..CLKS_PER_BIT
NUM_BITS, 9, bits strobed per packet (8 data + 1 stop); legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous active-low reset
enable_timer  input  1  run request from the receiver control FSM; low clears the block
shift_strobe  output  1  one-cycle pulse: sample/shift the serial input now
packet_done  output  1  one-cycle pulse: last bit of the packet has been strobed
bit_idx  output  4  number of bits strobed so far in the current packet (0..NUM_BITS)

Behaviour:
- Reset: synchronous, active-low. Sampled only on the clk rising edge.
  - Reset clears clk_cnt, bit_cnt and done_flag to 0.
  - All outputs are 0 in the cycle after the reset edge.
  - Reset has priority over enable_timer.
- Cycle numbering: cycle k is the cycle after the k-th rising edge at which enable_timer was sampled 1 since it last went high.
- Period counter clk_cnt, width $clog2(CLKS_PER_BIT+1):
  - Edge with enable_timer=0: clk_cnt <= 0.
  - Edge with enable_timer=1 and done_flag=0: if clk_cnt==CLKS_PER_BIT, clk_cnt <= 1; else clk_cnt <= clk_cnt+1.
  - Value in cycle k is ((k-1) mod CLKS_PER_BIT)+1.
- shift_strobe = (clk_cnt==SAMPLE_POINT) && (bit_cnt<NUM_BITS) && !done_flag.
  - Decoded from registers only; no combinational path from enable_timer.
  - The n-th strobe (n=1..NUM_BITS) occurs in cycle SAMPLE_POINT+(n-1)*CLKS_PER_BIT.
- Bit counter bit_cnt, 4 bits:
  - Increments on every edge where shift_strobe=1.
  - Cleared to 0 on any edge with enable_timer=0.
  - Saturates at NUM_BITS. bit_idx = bit_cnt.
- Completion:
  - done_flag is set on the edge where shift_strobe=1 and bit_cnt==NUM_BITS-1.
  - packet_done = done_flag && !done_seen: high for exactly one cycle, the cycle immediately after the last strobe.
  - done_seen is set one edge after done_flag.
  - While enable_timer stays 1 after completion, clk_cnt and bit_cnt freeze. No further shift_strobe or packet_done until enable_timer goes low and returns high.
- Enable dropped mid-packet: the next edge clears clk_cnt, bit_cnt, done_flag and done_seen. No strobe or done is produced from that cycle on. A later enable restarts from cycle numbering 1.
- Enable low for a single cycle between packets is sufficient for a full restart.
- Parameter legality is checked at elaboration with $error: SAMPLE_POINT outside 1..CLKS_PER_BIT, or NUM_BITS > 15.

Decomposition:
- Package rx_timer_pkg holds:
  - constants DEFAULT_CLKS_PER_BIT=10, DEFAULT_SAMPLE_POINT=10, DEFAULT_NUM_BITS=9;
  - function cnt_width(int max) returning $clog2(max+1).
- Sub-module sync_flex_counter, instantiated twice (period counter and bit counter).
  - Parameterised width.
  - Inputs: sync active-low reset, clear, count_enable, rollover_val.
  - Output: count.
  - Synchronous clear has priority over count.
- Top-level logic: strobe decode, done_flag/done_seen registers, freeze gating of count_enable.

Test Plan:
1. Defaults; hold n_rst=0 for 3 edges with enable_timer=1 -> shift_strobe, packet_done and bit_idx all 0 throughout; after release with enable=1, first strobe in cycle 10.
2. Defaults; enable_timer rises and holds -> strobes in cycles 10,20,...,90 (9 pulses, each 1 cycle wide); packet_done only in cycle 91; bit_idx=9 from cycle 91 on.
3. Defaults; enable held 1 for 200 cycles -> exactly 9 strobes and 1 packet_done; no strobe at cycles 100+; bit_idx stays 9.
4. Defaults; enable dropped at cycle 35 (after 3 strobes), re-raised 2 cycles later -> no strobe or done while low; bit_idx=0; next strobe 10 cycles after the re-raise; full 9-strobe packet completes normally.
5. Back-to-back packets: enable low for exactly 1 cycle after packet_done, then high -> second packet strobes at relative cycles 10..90, packet_done at relative cycle 91.
6. CLKS_PER_BIT=16, SAMPLE_POINT=8, NUM_BITS=9 -> strobes at cycles 8,24,...,136; packet_done at cycle 137; assert n_rst=0 at cycle 50 -> all outputs 0 on the next cycle.
